// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction fetch front end.
// Owns the fetch PC, issues one instruction-memory request at a time and
// hands each fetched word to decode over a valid/ready handshake. Redirects
// from the execute-stage branch unit retarget the PC and discard any fetch
// already in flight, so decode only ever sees the new stream.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   redirect_valid, branch         PC-select from execute (01 target, 10 ALU)
//   branch_target, alu_out         redirect target candidates
//   imem_req_valid/ready/addr      fetch request channel
//   imem_resp_valid/data           fetch response (one per accepted request)
//   if_valid/ready, if_instr/pc    instruction handoff to decode
//   misalign_fault                 one-cycle pulse on a misaligned redirect
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [1:0]  branch,
  input  logic [31:0] branch_target,
  input  logic [31:0] alu_out,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_fault
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        fault_q, fault_d;

  logic        redir_sel, redir_ok;
  logic [31:0] target;

  // jal/jalr targets have bit0 forced low before the alignment check.
  assign redir_sel = redirect_valid && (branch == 2'b01 || branch == 2'b10);
  assign target    = (branch == 2'b01) ? branch_target : (alu_out & ~32'h1);
  assign redir_ok  = redir_sel && (target[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    fault_d    = redir_sel && !redir_ok;

    if (redir_ok) begin
      pc_d = target;
      case (state_q)
        S_REQ: begin
          // A request accepted this cycle is already stale.
          if (imem_req_ready) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              instr_d = imem_resp_data;
              ipc_d   = fetch_pc_q;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (if_ready) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= 32'h0;
      drop_q     <= 1'b0;
      instr_q    <= 32'h0;
      ipc_q      <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == S_HOLD);
  assign if_instr       = instr_q;
  assign if_pc          = ipc_q;
  // Masked so a pulse from the cycle before reset cannot leak out during rst.
  assign misalign_fault = fault_q && !rst;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [1:0]  branch;
  logic [31:0] branch_target, alu_out;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        misalign_fault;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .branch(branch),
    .branch_target(branch_target), .alu_out(alu_out),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .misalign_fault(misalign_fault)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a transaction-level view of the fetch front end.
  // m_out: a memory request is outstanding; m_stale: its data is unwanted;
  // m_have: an instruction is waiting for decode.
  logic [31:0] m_pc, m_fpc, m_instr, m_ipc;
  bit          m_out, m_stale, m_have, m_fault;
  bit          cur_rst;

  // Memory environment: one outstanding request, fixed or random latency.
  bit          mem_pend = 0;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_force = 1;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_fpc = 0; m_instr = 0; m_ipc = 0;
    m_out = 0; m_stale = 0; m_have = 0; m_fault = 0;
  endtask

  // One clock cycle, entered and left at a negedge: check outputs, drive
  // inputs, advance the model, clock the DUT.
  task automatic step(input bit r, input bit rdy, input bit ifr, input bit rv,
                      input logic [1:0] br, input logic [31:0] bt, input logic [31:0] ao);
    bit m_reqv, acc, got, redir, bad, ok, dut_acc, rsp;
    logic [31:0] tgt, rdata, a_s;
    m_reqv = !m_out && !m_have;
    chk("req_valid", imem_req_valid, m_reqv);
    if (m_reqv) chk("req_addr", imem_req_addr, m_pc);
    chk("if_valid", if_valid, m_have);
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
    chk("misalign", misalign_fault, m_fault && !cur_rst);

    rsp = 0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin rsp = 1; mem_pend = 0; end
    end
    rdata = rsp ? mdata(mem_addr) : $urandom;
    rst = r; imem_req_ready = rdy; imem_resp_valid = rsp; imem_resp_data = rdata;
    if_ready = ifr; redirect_valid = rv; branch = br; branch_target = bt; alu_out = ao;
    cur_rst = r;
    dut_acc = imem_req_valid && rdy;
    a_s = imem_req_addr;

    if (r) model_reset();
    else begin
      redir = rv && (br == 2'b01 || br == 2'b10);
      tgt = (br == 2'b01) ? bt : (ao & ~32'd1);
      bad = redir && (tgt[1:0] != 2'b00);
      ok = redir && !bad;
      acc = m_reqv && rdy;
      got = m_out && rsp;
      m_fault = bad;
      if (ok) begin
        if (got) begin m_out = 0; m_stale = 0; end
        else if (m_out) m_stale = 1;
        if (acc) begin m_out = 1; m_stale = 1; end
        m_have = 0;
        m_pc = tgt;
      end else begin
        if (m_have && ifr) m_have = 0;
        if (acc) begin m_out = 1; m_stale = 0; m_fpc = m_pc; m_pc = m_pc + 32'd4; end
        if (got) begin
          m_out = 0;
          if (m_stale) m_stale = 0;
          else begin m_have = 1; m_instr = rdata; m_ipc = m_fpc; end
        end
      end
    end

    @(posedge clk);
    if (dut_acc && !r) begin
      mem_pend = 1;
      mem_addr = a_s;
      mem_cnt  = (lat_force != 0) ? lat_force : int'($urandom_range(1, 3));
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy, input bit ifr);
    step(0, rdy, ifr, 0, 2'b00, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    if_ready = 0; redirect_valid = 0; branch = 0; branch_target = 0; alu_out = 0;
    cur_rst = 1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    step(1, 0, 0, 0, 2'b00, 0, 0);
    chk("rst_req_addr", imem_req_addr, RST_PC);

    // 1: sequential fetch, 1-cycle memory, decode always ready
    lat_force = 1;
    idle(1, 1); idle(1, 1);
    chk("t1_pc0", if_pc, 32'h0);
    chk("t1_instr0", if_instr, mdata(32'h0));
    for (int i = 1; i < 3; i++) begin
      idle(1, 1); idle(1, 1); idle(1, 1);
      chk("t1_pc", if_pc, 32'(i * 4));
    end

    // 2: decode stalls in HOLD, then releases
    repeat (3) idle(1, 0);
    chk("t2_hold_pc", if_pc, 32'h8);
    idle(1, 1);
    chk("t2_next_addr", imem_req_addr, 32'hC);

    // 3: redirect while waiting on 0x10, stale response 2 cycles later
    idle(1, 1); idle(1, 1); idle(1, 1);
    lat_force = 3;
    idle(1, 1);
    step(0, 1, 1, 1, 2'b01, 32'h100, 32'h0);
    idle(1, 1); idle(1, 1);
    chk("t3_addr", imem_req_addr, 32'h100);
    lat_force = 1;
    idle(1, 0); idle(1, 0);
    chk("t3_pc", if_pc, 32'h100);

    // 4: misaligned jump while holding, then an aligned one
    step(0, 1, 0, 1, 2'b10, 32'h0, 32'h203);
    chk("t4_fault", misalign_fault, 1'b1);
    idle(1, 0);
    chk("t4_fault_clr", misalign_fault, 1'b0);
    idle(1, 1);
    chk("t4_seq_addr", imem_req_addr, 32'h104);
    idle(1, 0); idle(1, 0);
    step(0, 1, 0, 1, 2'b10, 32'h0, 32'h301);
    chk("t4_jump_addr", imem_req_addr, 32'h300);

    // 5: redirect in REQ, unaccepted then accepted
    step(0, 0, 0, 1, 2'b01, 32'h40, 32'h0);
    chk("t5_addr_unacc", imem_req_addr, 32'h40);
    step(0, 1, 0, 1, 2'b01, 32'h40, 32'h0);
    idle(1, 0);
    chk("t5_addr_acc", imem_req_addr, 32'h40);
    chk("t5_no_instr", if_valid, 1'b0);
    idle(1, 0); idle(1, 0);
    chk("t5_pc", if_pc, 32'h40);

    // 6: no-op selects in HOLD, PC wrap, reset mid-WAIT
    step(0, 1, 0, 1, 2'b00, 32'h999, 32'h777);
    step(0, 1, 0, 1, 2'b11, 32'h888, 32'h666);
    chk("t6_hold_valid", if_valid, 1'b1);
    chk("t6_hold_pc", if_pc, 32'h40);
    step(0, 1, 0, 1, 2'b01, 32'hFFFF_FFFC, 32'h0);
    chk("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    idle(1, 0); idle(1, 0);
    chk("t6_top_pc", if_pc, 32'hFFFF_FFFC);
    idle(1, 1);
    chk("t6_wrap_addr", imem_req_addr, 32'h0);
    lat_force = 3;
    idle(1, 1);
    step(1, 0, 0, 0, 2'b00, 0, 0);
    chk("t6_rst_addr", imem_req_addr, RST_PC);
    for (int i = 0; i < 8 && mem_pend; i++) idle(0, 0);
    if (mem_pend) chk("t6_late_resp_timeout", 32'h1, 32'h0);

    // Random traffic: aligned redirects of every select, random handshakes
    lat_force = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] x, y;
      bit rv;
      x  = $urandom;
      y  = $urandom;
      rv = ($urandom_range(0, 5) == 0);
      step(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) < 3), rv,
           2'($urandom_range(0, 3)), x & ~32'h3, y & ~32'h2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
